// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder stage is reused for WIDTH cycles, LSB first,
// with the carry held in a register between bits.

module full_adder (
  input  logic in_1,
  input  logic in_2,
  input  logic cin,
  output logic sum,
  output logic count
);
  assign sum   = in_1 ^ in_2 ^ cin;
  assign count = (in_1 & in_2) | (in_1 & cin) | (in_2 & cin);
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds valid and data stable until that edge, and ready never
// depends combinationally on valid.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_count;

  full_adder u_fa (
    .in_1  (a_sr[0]),
    .in_2  (b_sr[0]),
    .cin   (carry_r),
    .sum   (fa_sum),
    .count (fa_count)
  );

  // New bit enters at the MSB so the LSB-first stream lands in order;
  // written this way so WIDTH = 1 needs no special slice.
  always_comb begin
    sum_next            = sum_sr >> 1;
    sum_next[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr      <= in_a;
            b_sr      <= in_b;
            carry_r   <= in_cin;
            sum_sr    <= '0;
            cnt       <= '0;
            state     <= CALC;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
          end
        end
        CALC: begin
          sum_sr  <= sum_next;
          carry_r <= fa_count;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_sum   = sum_sr;
  assign out_cout  = carry_r;
  assign state_dbg = state;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder engine built around one full_adder instance. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and shifts them LSB-first through the full_adder, one bit per clock, with the carry fed back through a register. It collects the sum bits and presents the WIDTH-bit sum and final carry on a valid/ready output. It trades throughput for area: one full_adder instead of a WIDTH-bit ripple chain.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
sys_clk  input  1  system clock; all state changes on its rising edge
sys_rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set on in_a/in_b/in_cin is valid
in_ready  output  1  block can accept operands; equals (state == IDLE)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in for bit 0
out_valid  output  1  out_sum/out_cout hold a completed result
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH  sum of in_a + in_b + in_cin, modulo 2^WIDTH
out_cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: single clock sys_clk. sys_rst is asynchronous and active-high. While sys_rst is high:
  - state = IDLE.
  - a_sr, b_sr, sum_sr, carry_r and cnt are all 0.
  - out_valid = 0, out_sum = 0, out_cout = 0, busy = 0, in_ready = 1.
  - in_valid is ignored.
- Reset mid-operation: asserting sys_rst in any state aborts the operation immediately. No result is produced for the aborted operands.
- States: IDLE, CALC, DONE. Encoding is free.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid && in_ready: a_sr <= in_a, b_sr <= in_b, carry_r <= in_cin, sum_sr <= 0, cnt <= 0, state <= CALC.
  - Otherwise the state holds.
- CALC, one bit per cycle:
  - full_adder inputs: in_1 = a_sr[0], in_2 = b_sr[0], cin = carry_r.
  - Each edge: sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}; carry_r <= fa_count; a_sr and b_sr shift right by 1 with zero fill; cnt <= cnt + 1.
  - When cnt == WIDTH-1 at the edge, state <= DONE.
  - CALC lasts exactly WIDTH cycles. With WIDTH = 1, CALC lasts exactly one cycle.
- DONE:
  - out_valid = 1, out_sum = sum_sr, out_cout = carry_r.
  - Values stay stable until the handshake completes.
  - On an edge with out_ready = 1: state <= IDLE, and out_valid drops after that edge.
- Output timing: out_valid, out_sum and out_cout are driven from registers or state decode only, with no combinational path from in_* to out_*.
- Latency: if operands are accepted at edge E0, out_valid is first high after edge E0+WIDTH.
- Throughput: with out_ready tied high, the next operands can be accepted at edge E0+WIDTH+2, giving one result per WIDTH+2 cycles.
- Back-pressure and ignored inputs:
  - in_ready = 0 throughout CALC and DONE. in_valid asserted there is ignored, and the upstream must hold its data.
  - No input is accepted in the same cycle as the output handshake; IDLE is always visited for at least one cycle.
- out_ready asserted outside DONE has no effect.
- Overflow: the sum wraps modulo 2^WIDTH, and the overflow bit appears only on out_cout.
- cnt width: $clog2(WIDTH+1) bits, with no wrap within a valid operation.

Test Plan:
- WIDTH=8. Accept in_a=0x3C, in_b=0x5A, in_cin=0 at edge E0 -> out_valid rises after E0+8; out_sum=0x96, out_cout=0; busy=1 from E0 until the out handshake.
- in_a=0xFF, in_b=0x01, in_cin=0 -> out_sum=0x00, out_cout=1. Then in_a=0xFF, in_b=0xFF, in_cin=1 -> out_sum=0xFF, out_cout=1.
- Back-pressure: out_ready held at 0 for 5 cycles in DONE -> out_valid=1, out_sum and out_cout unchanged, in_ready=0. A new in_valid during those cycles is not accepted. Release out_ready -> IDLE on the next edge.
- Back-to-back with out_ready=1 and in_valid held high with changing data -> accepts occur at E0, E0+10, E0+20. Each result matches its operands; no input is dropped or duplicated when checked against a reference model.
- Reset mid-CALC: assert sys_rst at cnt=3 of in_a=0x12 + in_b=0x34 -> outputs go to reset values immediately, with no out_valid for that operation. After release, 0x01+0x01 gives 0x02, cout=0.
- WIDTH=1 build: all 8 combinations of a, b, cin -> sum and cout match the truth table; out_valid appears one edge after acceptance.
